// File: rtl/sdram_arbiter.sv
// Three-port slot arbiter for an SDRAM controller. It makes one grant decision per
// 8-clock slot at the sync-aligned slot boundary and acks the previous slot's owner there.
module sdram_arbiter #(
   parameter int INIT_SLOTS  = 32,
   parameter int STARVE_MAX  = 4,
   parameter int REFRESH_MAX = 48
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sync,
   input  logic [2:0]  req,
   input  logic [2:0]  we,
   input  logic [71:0] addr,
   input  logic [5:0]  ds,
   input  logic [47:0] din,
   output logic [2:0]  ack,
   output logic [15:0] dout,
   output logic        mem_oe,
   output logic        mem_we,
   output logic [23:0] mem_addr,
   output logic [1:0]  mem_ds,
   output logic [15:0] mem_din,
   input  logic [15:0] mem_dout
);
   localparam int INIT_W   = $clog2(INIT_SLOTS + 2);
   localparam int STARVE_W = $clog2(STARVE_MAX + 2);
   localparam int BUSY_W   = $clog2(REFRESH_MAX + 2);

   logic [2:0]          p_reg, p_next;
   logic [INIT_W-1:0]   init_reg, init_next;
   logic [STARVE_W-1:0] starve_reg, starve_next;
   logic [BUSY_W-1:0]   busy_reg, busy_next;
   logic                fly_valid_reg, fly_valid_next;
   logic [1:0]          fly_port_reg, fly_port_next;
   logic                fly_we_reg, fly_we_next;
   logic [2:0]          ack_reg, ack_next;
   logic [15:0]         dout_reg, dout_next;
   logic                mem_oe_reg, mem_oe_next;
   logic                mem_we_reg, mem_we_next;
   logic [23:0]         mem_addr_reg, mem_addr_next;
   logic [1:0]          mem_ds_reg, mem_ds_next;
   logic [15:0]         mem_din_reg, mem_din_next;

   logic [23:0] addr_arr [0:2];
   logic [1:0]  ds_arr   [0:2];
   logic [15:0] din_arr  [0:2];

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_unpack
         assign addr_arr[gi] = addr[24*gi +: 24];
         assign ds_arr[gi]   = ds[2*gi +: 2];
         assign din_arr[gi]  = din[16*gi +: 16];
      end
   endgenerate

   logic       arb_edge;
   logic [2:0] done_mask;
   logic [2:0] eligible;
   logic       allow;
   logic       starving;
   logic       grant_valid;
   logic [1:0] grant_port;

   // Grant decision; the port finishing its slot at this edge may not win the next one.
   always_comb begin
      arb_edge    = (p_reg == 3'd7) && sync;
      done_mask   = fly_valid_reg ? (3'b001 << fly_port_reg) : 3'b000;
      eligible    = req & ~done_mask;
      allow       = (init_reg == '0) && (busy_reg != BUSY_W'(REFRESH_MAX));
      starving    = (starve_reg == STARVE_W'(STARVE_MAX));
      grant_valid = 1'b0;
      grant_port  = 2'd0;
      if (allow) begin
         if (eligible[2] && starving) begin
            grant_valid = 1'b1;
            grant_port  = 2'd2;
         end else if (eligible[0]) begin
            grant_valid = 1'b1;
            grant_port  = 2'd0;
         end else if (eligible[1]) begin
            grant_valid = 1'b1;
            grant_port  = 2'd1;
         end else if (eligible[2]) begin
            grant_valid = 1'b1;
            grant_port  = 2'd2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p_reg         <= 3'd7;
         init_reg      <= INIT_W'(INIT_SLOTS);
         starve_reg    <= '0;
         busy_reg      <= '0;
         fly_valid_reg <= 1'b0;
         fly_port_reg  <= 2'd0;
         fly_we_reg    <= 1'b0;
         ack_reg       <= 3'b000;
         dout_reg      <= 16'h0000;
         mem_oe_reg    <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= 24'h000000;
         mem_ds_reg    <= 2'b00;
         mem_din_reg   <= 16'h0000;
      end else begin
         p_reg         <= p_next;
         init_reg      <= init_next;
         starve_reg    <= starve_next;
         busy_reg      <= busy_next;
         fly_valid_reg <= fly_valid_next;
         fly_port_reg  <= fly_port_next;
         fly_we_reg    <= fly_we_next;
         ack_reg       <= ack_next;
         dout_reg      <= dout_next;
         mem_oe_reg    <= mem_oe_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_ds_reg    <= mem_ds_next;
         mem_din_reg   <= mem_din_next;
      end
   end

   always_comb begin
      p_next         = (p_reg == 3'd7 && !sync) ? p_reg : p_reg + 3'd1;
      init_next      = init_reg;
      starve_next    = starve_reg;
      busy_next      = busy_reg;
      fly_valid_next = fly_valid_reg;
      fly_port_next  = fly_port_reg;
      fly_we_next    = fly_we_reg;
      ack_next       = 3'b000;
      dout_next      = dout_reg;
      mem_oe_next    = mem_oe_reg;
      mem_we_next    = mem_we_reg;
      mem_addr_next  = mem_addr_reg;
      mem_ds_next    = mem_ds_reg;
      mem_din_next   = mem_din_reg;
      if (arb_edge) begin
         if (fly_valid_reg) begin
            ack_next = done_mask;
            if (!fly_we_reg)
               dout_next = mem_dout;
         end
         fly_valid_next = grant_valid;
         fly_port_next  = grant_port;
         fly_we_next    = we[grant_port];
         mem_oe_next    = grant_valid & ~we[grant_port];
         mem_we_next    = grant_valid & we[grant_port];
         if (grant_valid) begin
            mem_addr_next = addr_arr[grant_port];
            mem_ds_next   = ds_arr[grant_port];
            mem_din_next  = din_arr[grant_port];
         end
         if (init_reg != '0)
            init_next = init_reg - 1'b1;
         // Forced refresh slots and init slots both count as idle and restart the busy run.
         busy_next = grant_valid ? busy_reg + 1'b1 : '0;
         if (!req[2] || (grant_valid && grant_port == 2'd2))
            starve_next = '0;
         else if (eligible[2] && !starving)
            starve_next = starve_reg + 1'b1;
      end
   end

   always_comb begin
      ack      = ack_reg;
      dout     = dout_reg;
      mem_oe   = mem_oe_reg;
      mem_we   = mem_we_reg;
      mem_addr = mem_addr_reg;
      mem_ds   = mem_ds_reg;
      mem_din  = mem_din_reg;
   end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter: slot-level reference model of the arbitration rules
// plus three requesters that hold req until ack and re-request mid-slot.
module tb_sdram_arbiter;
   localparam int INIT_SLOTS  = 32;
   localparam int STARVE_MAX  = 4;
   localparam int REFRESH_MAX = 48;

   logic        clk = 1'b0;
   logic        reset;
   logic        sync;
   logic [2:0]  req;
   logic [2:0]  we;
   logic [71:0] addr;
   logic [5:0]  ds;
   logic [47:0] din;
   logic [2:0]  ack;
   logic [15:0] dout;
   logic        mem_oe;
   logic        mem_we;
   logic [23:0] mem_addr;
   logic [1:0]  mem_ds;
   logic [15:0] mem_din;
   logic [15:0] mem_dout;

   always #5 clk = ~clk;

   sdram_arbiter #(
      .INIT_SLOTS (INIT_SLOTS),
      .STARVE_MAX (STARVE_MAX),
      .REFRESH_MAX(REFRESH_MAX)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sync    (sync),
      .req     (req),
      .we      (we),
      .addr    (addr),
      .ds      (ds),
      .din     (din),
      .ack     (ack),
      .dout    (dout),
      .mem_oe  (mem_oe),
      .mem_we  (mem_we),
      .mem_addr(mem_addr),
      .mem_ds  (mem_ds),
      .mem_din (mem_din),
      .mem_dout(mem_dout)
   );

   int checks = 0;
   int passed = 0;
   int slot_no = 0;

   // Reference model state, kept per slot rather than per clock.
   int          m_init, m_starve, m_busy, m_port;
   bit          m_fly, m_fly_we;
   logic [15:0] m_dout;
   logic        m_oe, m_we;
   logic [23:0] m_addr;
   logic [1:0]  m_ds;
   logic [15:0] m_din;
   logic [2:0]  exp_ack;

   bit track_runs = 1'b0;
   bit armed      = 1'b0;
   bit did_reset  = 1'b0;
   int run        = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp)
         passed++;
      else
         $display("FAIL %s: got %0h, expected %0h (slot %0d)", tag, got, exp, slot_no);
   endtask

   task automatic model_reset;
      m_init   = INIT_SLOTS;
      m_starve = 0;
      m_busy   = 0;
      m_port   = 0;
      m_fly    = 1'b0;
      m_fly_we = 1'b0;
      m_dout   = 16'h0000;
      m_oe     = 1'b0;
      m_we     = 1'b0;
      m_addr   = 24'h000000;
      m_ds     = 2'b00;
      m_din    = 16'h0000;
   endtask

   // Applies the slot-boundary rules to the inputs present just before the edge.
   task automatic model_arbitrate;
      logic [2:0] elig;
      int g;
      exp_ack = 3'b000;
      if (m_fly) begin
         exp_ack[m_port] = 1'b1;
         if (!m_fly_we)
            m_dout = mem_dout;
         $display("slot %0d: port %0d %s done, dout=%04h", slot_no, m_port,
                  m_fly_we ? "write" : "read", m_dout);
      end
      elig = req;
      if (m_fly)
         elig[m_port] = 1'b0;
      g = -1;
      if (m_init > 0)
         m_init--;
      else if (m_busy < REFRESH_MAX) begin
         if (elig[2] && m_starve == STARVE_MAX)
            g = 2;
         else
            for (int i = 0; i < 3; i++)
               if (g < 0 && elig[i])
                  g = i;
      end
      m_busy = (g >= 0) ? m_busy + 1 : 0;
      if (!req[2] || g == 2)
         m_starve = 0;
      else if (elig[2] && m_starve < STARVE_MAX)
         m_starve++;
      m_fly = (g >= 0);
      if (g >= 0) begin
         m_port   = g;
         m_fly_we = we[g];
         m_oe     = ~we[g];
         m_we     = we[g];
         m_addr   = addr[24*g +: 24];
         m_ds     = ds[2*g +: 2];
         m_din    = din[16*g +: 16];
      end else begin
         m_oe = 1'b0;
         m_we = 1'b0;
      end
   endtask

   task automatic raise(input int pct);
      for (int i = 0; i < 3; i++) begin
         if (!req[i] && int'($urandom_range(99)) < pct) begin
            req[i]          = 1'b1;
            we[i]           = 1'($urandom_range(1));
            addr[24*i +: 24] = 24'($urandom);
            ds[2*i +: 2]    = 2'($urandom_range(3));
            din[16*i +: 16] = 16'($urandom);
         end
      end
   endtask

   task automatic do_slot(input int gap, input bit rst_mid, input int pct);
      logic granted;
      for (int k = 0; k < gap; k++) begin
         sync = 1'b0;
         @(posedge clk); #1;
         check("gap_ack", 32'(ack), 32'(3'b000));
         check("gap_oe", 32'(mem_oe), 32'(m_oe));
      end
      sync     = 1'b1;
      mem_dout = 16'($urandom);
      slot_no++;
      model_arbitrate();
      @(posedge clk); #1;
      check("ack", 32'(ack), 32'(exp_ack));
      check("dout", 32'(dout), 32'(m_dout));
      check("mem_oe", 32'(mem_oe), 32'(m_oe));
      check("mem_we", 32'(mem_we), 32'(m_we));
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
      check("mem_ds", 32'(mem_ds), 32'(m_ds));
      check("mem_din", 32'(mem_din), 32'(m_din));
      granted = mem_oe | mem_we;
      if (track_runs) begin
         if (granted)
            run++;
         else begin
            if (armed)
               check("refresh_run", 32'(run), 32'(REFRESH_MAX));
            armed = 1'b1;
            run   = 0;
         end
      end
      req  = req & ~ack;
      sync = 1'b0;
      for (int c = 0; c < 7; c++) begin
         sync = 1'($urandom_range(1));
         if (c == 3) begin
            if (rst_mid && m_fly) begin
               reset = 1'b1;
               @(posedge clk); #1;
               reset = 1'b0;
               sync  = 1'b0;
               check("rst_ack", 32'(ack), 32'(3'b000));
               check("rst_dout", 32'(dout), 32'(16'h0000));
               check("rst_oe", 32'(mem_oe), 32'(1'b0));
               check("rst_we", 32'(mem_we), 32'(1'b0));
               check("rst_addr", 32'(mem_addr), 32'(24'h000000));
               check("rst_ds", 32'(mem_ds), 32'(2'b00));
               check("rst_din", 32'(mem_din), 32'(16'h0000));
               model_reset();
               did_reset = 1'b1;
               return;
            end
            raise(pct);
         end
         @(posedge clk); #1;
         if (c == 0)
            check("ack_pulse", 32'(ack), 32'(3'b000));
      end
      sync = 1'b0;
      check("hold_oe", 32'(mem_oe), 32'(m_oe));
      check("hold_we", 32'(mem_we), 32'(m_we));
      check("hold_addr", 32'(mem_addr), 32'(m_addr));
   endtask

   function automatic int rand_gap();
      return ($urandom_range(3) == 0) ? int'($urandom_range(1, 3)) : 0;
   endfunction

   initial begin
      reset    = 1'b1;
      sync     = 1'b0;
      req      = 3'b000;
      we       = 3'b000;
      addr     = '0;
      ds       = '0;
      din      = '0;
      mem_dout = 16'h0000;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_ack", 32'(ack), 32'(3'b000));
      check("reset_dout", 32'(dout), 32'(16'h0000));
      check("reset_oe", 32'(mem_oe), 32'(1'b0));
      check("reset_we", 32'(mem_we), 32'(1'b0));
      check("reset_addr", 32'(mem_addr), 32'(24'h000000));

      // CPU read held through the init window: first grant lands in slot INIT_SLOTS+1.
      req[1]      = 1'b1;
      we[1]       = 1'b0;
      addr[47:24] = 24'h012345;
      ds[3:2]     = 2'b11;
      for (int s = 0; s < INIT_SLOTS + 1; s++)
         do_slot(0, 1'b0, 0);
      check("first_grant_oe", 32'(mem_oe), 32'(1'b1));
      check("first_grant_addr", 32'(mem_addr), 32'(24'h012345));

      for (int s = 0; s < 30; s++)
         do_slot(rand_gap(), 1'b0, 40);

      track_runs = 1'b1;
      for (int s = 0; s < 120; s++)
         do_slot(0, 1'b0, 100);
      track_runs = 1'b0;

      for (int k = 0; k < 10 && !did_reset; k++)
         do_slot(0, 1'b1, 100);
      check("mid_reset_done", 32'(did_reset), 32'(1'b1));

      for (int s = 0; s < 80; s++)
         do_slot(rand_gap(), 1'b0, 40);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
